// File: rtl/clk_div_pkg.sv
// Shared types and helpers for the programmable clock divider bank.
package clk_div_pkg;

  // Smallest divide ratio a channel will ever run at.
  localparam int DIV_MIN = 2;

  // Storage width of a ratio inside a channel. Narrower DIV_W inputs are
  // zero-extended into it; synthesis trims the constant-zero upper bits.
  localparam int MAX_DIV_W = 16;

  // One channel's configuration: enable plus divide ratio.
  typedef struct packed {
    logic                 en;
    logic [MAX_DIV_W-1:0] div;
  } chan_cfg_t;

  // Ratios below DIV_MIN are raised to DIV_MIN; there is no bypass mode.
  function automatic logic [MAX_DIV_W-1:0] clamp_div(input logic [MAX_DIV_W-1:0] div);
    if (div < MAX_DIV_W'(DIV_MIN)) begin
      return MAX_DIV_W'(DIV_MIN);
    end
    return div;
  endfunction

endpackage

// File: rtl/clk_div_chan.sv
// One divider channel: active and pending configuration, period counter,
// and registered divided-clock / tick outputs.
//
// A channel is either idle (active.en = 0, counter held at 0, outputs low)
// or running. While running, a new configuration is parked in the pending
// register and only takes effect when the counter wraps, so a period is
// never cut short and no runt pulse can reach the output. SYNC forces an
// immediate restart at count 0 after folding in any pending configuration.
module clk_div_chan
  import clk_div_pkg::*;
#(
  parameter int DEFAULT_DIV = 2
) (
  input  logic      clk_i,
  input  logic      rst_i,
  input  logic      wr_i,      // configuration write aimed at this channel
  input  chan_cfg_t wr_cfg_i,  // already-clamped configuration being written
  input  logic      sync_i,    // bank-wide restart
  output logic      clk_o,
  output logic      tick_o,
  output logic      pend_o
);

  chan_cfg_t            act_q,    act_d;
  chan_cfg_t            pend_q,   pend_d;
  logic                 pend_v_q, pend_v_d;
  logic [MAX_DIV_W-1:0] cnt_q,    cnt_d;
  logic                 clk_q,    clk_d;
  logic                 tick_q,   tick_d;

  logic                 at_wrap;
  chan_cfg_t            sync_cfg;

  // Last cycle of the current period of a running channel.
  assign at_wrap = act_q.en && (cnt_q == (act_q.div - MAX_DIV_W'(1)));

  // Configuration SYNC restarts with: a same-cycle write wins, otherwise the
  // pending value if any, otherwise the current active value.
  assign sync_cfg = wr_i     ? wr_cfg_i :
                    pend_v_q ? pend_q   : act_q;

  // Next-state: counter advance, boundary loads, write merge and SYNC.
  always_comb begin
    act_d    = act_q;
    pend_d   = pend_q;
    pend_v_d = pend_v_q;
    cnt_d    = cnt_q;

    if (sync_i) begin
      // Restart at count 0 with the merged configuration; nothing stays pending.
      act_d    = sync_cfg;
      pend_v_d = 1'b0;
      cnt_d    = '0;
    end else if (wr_i && !act_q.en) begin
      // Idle channel: the write takes effect at once and starts a fresh period.
      act_d    = wr_cfg_i;
      pend_v_d = 1'b0;
      cnt_d    = '0;
    end else begin
      if (act_q.en) begin
        if (at_wrap) begin
          cnt_d = '0;
          if (pend_v_q) begin
            act_d    = pend_q;
            pend_v_d = 1'b0;
          end
        end else begin
          cnt_d = cnt_q + MAX_DIV_W'(1);
        end
      end
      // Write to a running channel is parked; a write landing on the wrap edge
      // becomes the next pending value after the old one was loaded above.
      if (wr_i) begin
        pend_d   = wr_cfg_i;
        pend_v_d = 1'b1;
      end
    end

    // Outputs are precomputed from next state so the pins come straight
    // from flops: high for the first floor(D/2) counts, tick on count 0.
    clk_d  = act_d.en && (cnt_d < (act_d.div >> 1));
    tick_d = act_d.en && (cnt_d == '0);
  end

  // State and output registers; reset drops everything to idle at once.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      act_q    <= '{en: 1'b0, div: MAX_DIV_W'(DEFAULT_DIV)};
      pend_q   <= '{en: 1'b0, div: MAX_DIV_W'(DEFAULT_DIV)};
      pend_v_q <= 1'b0;
      cnt_q    <= '0;
      clk_q    <= 1'b0;
      tick_q   <= 1'b0;
    end else begin
      act_q    <= act_d;
      pend_q   <= pend_d;
      pend_v_q <= pend_v_d;
      cnt_q    <= cnt_d;
      clk_q    <= clk_d;
      tick_q   <= tick_d;
    end
  end

  assign clk_o  = clk_q;
  assign tick_o = tick_q;
  assign pend_o = pend_v_q;

endmodule

// File: rtl/clk_div_bank.sv
// Bank of NUM_CH runtime-programmable integer clock dividers sharing one
// source clock, with a bank-wide SYNC that phase-aligns every channel.
//
// CFG_WE is a single-cycle strobe with no back-pressure: every write is
// accepted on the edge it is sampled. Writes to a channel index at or
// above NUM_CH match no channel and are dropped.
module clk_div_bank
  import clk_div_pkg::*;
#(
  parameter int NUM_CH      = 4,
  parameter int DIV_W       = 8,
  parameter int DEFAULT_DIV = 2,
  parameter int CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              CLK_IN,
  input  logic              RST_IN,
  input  logic              CFG_WE,
  input  logic [CH_W-1:0]   CFG_CH,
  input  logic [DIV_W-1:0]  CFG_DIV,
  input  logic              CFG_EN,
  input  logic              SYNC,
  output logic [NUM_CH-1:0] CLK_OUT,
  output logic [NUM_CH-1:0] TICK,
  output logic [NUM_CH-1:0] CFG_PEND
);

  chan_cfg_t         wr_cfg;
  logic [NUM_CH-1:0] wr_sel;

  // Clamp once here so every channel sees a legal ratio.
  assign wr_cfg = '{en: CFG_EN, div: clamp_div(MAX_DIV_W'(CFG_DIV))};

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    // Write-address decode: exact match on the full channel field.
    assign wr_sel[i] = CFG_WE && (CFG_CH == CH_W'(i));

    clk_div_chan #(
      .DEFAULT_DIV (DEFAULT_DIV)
    ) u_chan (
      .clk_i    (CLK_IN),
      .rst_i    (RST_IN),
      .wr_i     (wr_sel[i]),
      .wr_cfg_i (wr_cfg),
      .sync_i   (SYNC),
      .clk_o    (CLK_OUT[i]),
      .tick_o   (TICK[i]),
      .pend_o   (CFG_PEND[i])
    );
  end

endmodule

// File: tb/tb_clk_div_bank.sv
// Directed bench for clk_div_bank: four channels with one spare address bit
// so that out-of-range channel writes can be issued.
module tb_clk_div_bank;

  localparam int NUM_CH = 4;
  localparam int DIV_W  = 8;
  localparam int CH_W   = 3;

  logic              clk_in  = 1'b0;
  logic              rst_in  = 1'b1;
  logic              cfg_we  = 1'b0;
  logic [CH_W-1:0]   cfg_ch  = '0;
  logic [DIV_W-1:0]  cfg_div = '0;
  logic              cfg_en  = 1'b0;
  logic              sync    = 1'b0;
  logic [NUM_CH-1:0] clk_out;
  logic [NUM_CH-1:0] tick;
  logic [NUM_CH-1:0] cfg_pend;

  int vectors     = 0;
  int miscompares = 0;

  clk_div_bank #(
    .NUM_CH      (NUM_CH),
    .DIV_W       (DIV_W),
    .DEFAULT_DIV (2),
    .CH_W        (CH_W)
  ) dut (
    .CLK_IN   (clk_in),
    .RST_IN   (rst_in),
    .CFG_WE   (cfg_we),
    .CFG_CH   (cfg_ch),
    .CFG_DIV  (cfg_div),
    .CFG_EN   (cfg_en),
    .SYNC     (sync),
    .CLK_OUT  (clk_out),
    .TICK     (tick),
    .CFG_PEND (cfg_pend)
  );

  // Clock: 10 time-unit period.
  always #5 clk_in = ~clk_in;

  // Advance one edge and settle just after it.
  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic check_pins(input string tag, input logic [3:0] ec,
                            input logic [3:0] et, input logic [3:0] ep);
    check({tag, ".clk"},  clk_out,  ec);
    check({tag, ".tick"}, tick,     et);
    check({tag, ".pend"}, cfg_pend, ep);
  endtask

  // Reference waveform of a channel with ratio d at count k%d.
  function automatic logic hi(input int k, input int d);
    return (k % d) < (d / 2);
  endfunction

  function automatic logic tk(input int k, input int d);
    return (k % d) == 0;
  endfunction

  // Asynchronous reset: outputs must drop before any edge arrives.
  task automatic do_reset(input string tag);
    rst_in = 1'b1;
    #1;
    check_pins(tag, 4'b0000, 4'b0000, 4'b0000);
    step();
    rst_in = 1'b0;
  endtask

  // One-cycle configuration write; returns just after the sampling edge.
  task automatic cfg_write(input int ch, input int div, input logic en);
    cfg_we  = 1'b1;
    cfg_ch  = CH_W'(ch);
    cfg_div = DIV_W'(div);
    cfg_en  = en;
    step();
    cfg_we  = 1'b0;
  endtask

  initial begin
    // Reset state.
    step();
    check_pins("reset", 4'b0000, 4'b0000, 4'b0000);
    step();
    rst_in = 1'b0;

    // 1: ch0 D=4 from idle, applies at once.
    cfg_write(0, 4, 1'b1);
    for (int k = 0; k < 12; k++) begin
      check_pins($sformatf("t1.k%0d", k), {3'b000, hi(k, 4)}, {3'b000, tk(k, 4)}, 4'b0000);
      step();
    end

    // 2: ch1 D=4 running, D=6 written mid-period, applied at the wrap.
    do_reset("t2.rst");
    cfg_write(1, 4, 1'b1);
    check_pins("t2.c0", 4'b0010, 4'b0010, 4'b0000);
    step();
    check_pins("t2.c1", 4'b0010, 4'b0000, 4'b0000);
    cfg_write(1, 6, 1'b1);
    check_pins("t2.c2", 4'b0000, 4'b0000, 4'b0010);
    step();
    check_pins("t2.c3", 4'b0000, 4'b0000, 4'b0010);
    step();
    for (int k = 0; k < 12; k++) begin
      check_pins($sformatf("t2.k%0d", k), {2'b00, hi(k, 6), 1'b0}, {2'b00, tk(k, 6), 1'b0}, 4'b0000);
      step();
    end

    // 3: odd ratio, then clamping of 0 and 1 to 2.
    do_reset("t3.rst");
    cfg_write(2, 5, 1'b1);
    for (int k = 0; k < 10; k++) begin
      check_pins($sformatf("t3.d5.k%0d", k), {1'b0, hi(k, 5), 2'b00}, {1'b0, tk(k, 5), 2'b00}, 4'b0000);
      step();
    end
    do_reset("t3.rst0");
    cfg_write(2, 0, 1'b1);
    for (int k = 0; k < 6; k++) begin
      check_pins($sformatf("t3.d0.k%0d", k), {1'b0, hi(k, 2), 2'b00}, {1'b0, tk(k, 2), 2'b00}, 4'b0000);
      step();
    end
    do_reset("t3.rst1");
    cfg_write(2, 1, 1'b1);
    for (int k = 0; k < 6; k++) begin
      check_pins($sformatf("t3.d1.k%0d", k), {1'b0, hi(k, 2), 2'b00}, {1'b0, tk(k, 2), 2'b00}, 4'b0000);
      step();
    end

    // 4: channels started at different times, then SYNC aligns div2/4/8.
    do_reset("t4.rst");
    cfg_write(0, 2, 1'b1);
    step();
    cfg_write(1, 4, 1'b1);
    step();
    step();
    cfg_write(2, 8, 1'b1);
    sync = 1'b1;
    step();
    sync = 1'b0;
    for (int k = 0; k < 16; k++) begin
      check_pins($sformatf("t4.k%0d", k),
                 {1'b0, hi(k, 8), hi(k, 4), hi(k, 2)},
                 {1'b0, tk(k, 8), tk(k, 4), tk(k, 2)}, 4'b0000);
      step();
    end

    // 5: last pending write wins; out-of-range channel write is dropped.
    do_reset("t5.rst");
    cfg_write(3, 6, 1'b1);
    check_pins("t5.c0", 4'b1000, 4'b1000, 4'b0000);
    step();
    cfg_write(3, 10, 1'b1);
    check_pins("t5.c2", 4'b1000, 4'b0000, 4'b1000);
    cfg_write(3, 3, 1'b1);
    check_pins("t5.c3", 4'b0000, 4'b0000, 4'b1000);
    cfg_write(4, 20, 1'b1);
    check_pins("t5.c4", 4'b0000, 4'b0000, 4'b1000);
    step();
    check_pins("t5.c5", 4'b0000, 4'b0000, 4'b1000);
    step();
    for (int k = 0; k < 9; k++) begin
      check_pins($sformatf("t5.k%0d", k), {hi(k, 3), 3'b000}, {tk(k, 3), 3'b000}, 4'b0000);
      step();
    end

    // 6: disable mid-high-phase finishes the period, then stays low.
    do_reset("t6.rst");
    cfg_write(0, 6, 1'b1);
    check_pins("t6.c0", 4'b0001, 4'b0001, 4'b0000);
    step();
    cfg_write(0, 6, 1'b0);
    check_pins("t6.c2", 4'b0001, 4'b0000, 4'b0001);
    for (int c = 3; c < 6; c++) begin
      step();
      check_pins($sformatf("t6.c%0d", c), 4'b0000, 4'b0000, 4'b0001);
    end
    for (int k = 0; k < 4; k++) begin
      step();
      check_pins($sformatf("t6.off%0d", k), 4'b0000, 4'b0000, 4'b0000);
    end

    // 6b: reset mid-period with a pending write drops everything at once.
    cfg_write(0, 4, 1'b1);
    check_pins("t6.re0", 4'b0001, 4'b0001, 4'b0000);
    cfg_write(0, 8, 1'b1);
    check_pins("t6.re1", 4'b0001, 4'b0000, 4'b0001);
    #2;
    rst_in = 1'b1;
    #1;
    check_pins("t6.async", 4'b0000, 4'b0000, 4'b0000);
    step();
    rst_in = 1'b0;
    step();
    step();
    check_pins("t6.post", 4'b0000, 4'b0000, 4'b0000);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
